psg_write_arbiter: RTL and testbench

- Shares the YM2149_PSG_system register write bus (addr, data, wr_n) between two requesters.
  - Port A: CPU.
  - Port B: music-player or DMA sequencer.
- Accepted writes are queued in a small FIFO.
- A sequencer replays queued writes as paced, active-low write strobes with a guaranteed gap between writes.
- Sits in the clk domain, directly in front of the PSG system's addr/data/wr_n inputs.

---
 rtl/psg_write_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_psg_write_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_write_arbiter.sv
// Two-port round-robin write arbiter for the PSG register bus: FIFO plus paced wr_n sequencer.
// Optional shadow-register deduplication of redundant writes is enabled by defining PSG_WR_DEDUP_EN.
module psg_write_arbiter #(
    parameter int FIFO_AW    = 3,
    parameter int STROBE_CYC = 1,
    parameter int GAP_CYC    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [7:0]       a_addr,
    input  logic [7:0]       a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [7:0]       b_addr,
    input  logic [7:0]       b_data,
    output logic [7:0]       psg_addr,
    output logic [7:0]       psg_data,
    output logic             psg_wr_n,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_level,
    output logic             skip_pulse
);

    localparam int               DEPTH          = 2 ** FIFO_AW;
    localparam logic [7:0]       LP_STROBE_LOAD = 8'(STROBE_CYC - 1);
    localparam logic [7:0]       LP_GAP_LOAD    = 8'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam logic [FIFO_AW:0] LP_PTR_ONE     = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_GAP
    } state_t;

    logic [15:0]      r_mem [DEPTH];
    logic [FIFO_AW:0] r_wptr;
    logic [FIFO_AW:0] r_rptr;
    logic             r_lastGrantB;
    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [7:0]       r_psgAddr;
    logic [7:0]       r_psgData;
    logic             r_psgWrN;

    logic             w_full;
    logic             w_empty;
    logic             w_grantA;
    logic             w_grantB;
    logic             w_push;
    logic             w_pop;
    logic             w_discard;
    logic             w_issue;
    logic [15:0]      w_pushEntry;
    logic [15:0]      w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);

    // A tie goes to whichever requester did not win the previous transfer.
    assign w_grantA    = !w_full && a_valid && (!b_valid || r_lastGrantB);
    assign w_grantB    = !w_full && b_valid && (!a_valid || !r_lastGrantB);
    assign a_ready     = w_grantA;
    assign b_ready     = w_grantB;
    assign w_push      = w_grantA || w_grantB;
    assign w_pushEntry = w_grantA ? {a_addr, a_data} : {b_addr, b_data};

    assign w_head  = r_mem[r_rptr[FIFO_AW-1:0]];
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_issue = w_pop && !w_discard;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= w_pushEntry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_lastGrantB <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr       <= r_wptr + LP_PTR_ONE;
                r_lastGrantB <= w_grantB;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + LP_PTR_ONE;
            end
        end
    end

    // Address and data only change on the IDLE->STROBE transition, so they are stable under wr_n low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_psgWrN  <= 1'b1;
            r_psgAddr <= 8'd0;
            r_psgData <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_psgAddr <= w_head[15:8];
                        r_psgData <= w_head[7:0];
                        r_psgWrN  <= 1'b0;
                        r_cnt     <= LP_STROBE_LOAD;
                        r_state   <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (r_cnt == 8'd0) begin
                        r_psgWrN <= 1'b1;
                        if (GAP_CYC == 0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= LP_GAP_LOAD;
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_psgWrN <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PSG_WR_DEDUP_EN
    logic [7:0]  r_shadow [16];
    logic [15:0] r_shadowValid;
    logic        r_skipPulse;
    logic [3:0]  w_headReg;
    logic        w_headLow;

    assign w_headReg = w_head[11:8];
    assign w_headLow = (w_head[15:12] == 4'd0);

    // Register 13 retriggers the envelope on every write, so it is never treated as redundant.
    assign w_discard = w_pop && w_headLow && (w_headReg != 4'd13) &&
                       r_shadowValid[w_headReg] && (r_shadow[w_headReg] == w_head[7:0]);

    always_ff @(posedge clk) begin
        if (w_issue && w_headLow) begin
            r_shadow[w_headReg] <= w_head[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadowValid <= 16'd0;
            r_skipPulse   <= 1'b0;
        end else begin
            r_skipPulse <= w_discard;
            if (w_issue && w_headLow) begin
                r_shadowValid[w_headReg] <= 1'b1;
            end
        end
    end

    assign skip_pulse = r_skipPulse;
`else
    assign w_discard  = 1'b0;
    assign skip_pulse = 1'b0;
`endif

    assign psg_addr   = r_psgAddr;
    assign psg_data   = r_psgData;
    assign psg_wr_n   = r_psgWrN;
    assign busy       = !w_empty || (r_state != S_IDLE);
    assign fifo_level = r_wptr - r_rptr;

endmodule

// File: tb/tb_psg_write_arbiter.sv
// Self-checking bench for psg_write_arbiter: arbitration vector table, scoreboard of issued PSG writes,
// and hand-written sequences for latency, backpressure, mid-strobe reset, dedup and a short-strobe build.
`timescale 1ns/1ps
module tb_psg_write_arbiter;

    typedef struct {
        logic aV;
        logic bV;
        logic expA;
        logic expB;
    } vector_t;

    logic       clk;
    logic       rst;
    logic       aValid, aReady, bValid, bReady;
    logic [7:0] aAddr, aData, bAddr, bData;
    logic [7:0] psgAddr, psgData;
    logic       psgWrN, busy, skipPulse;
    logic [3:0] fifoLevel;

    logic       a2Valid, a2Ready, b2Valid, b2Ready;
    logic [7:0] a2Addr, a2Data, b2Addr, b2Data;
    logic [7:0] psgAddr2, psgData2;
    logic       psgWrN2, busy2, skipPulse2;
    logic [3:0] fifoLevel2;

    int          checks = 0;
    int          errors = 0;
    int          cycleCount = 0;
    int          strobeCount = 0;
    int          skipCount = 0;
    logic [15:0] expQ[$];
    logic        checkSpacing = 1'b1;

    psg_write_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(aValid), .a_ready(aReady), .a_addr(aAddr), .a_data(aData),
        .b_valid(bValid), .b_ready(bReady), .b_addr(bAddr), .b_data(bData),
        .psg_addr(psgAddr), .psg_data(psgData), .psg_wr_n(psgWrN),
        .busy(busy), .fifo_level(fifoLevel), .skip_pulse(skipPulse)
    );

    psg_write_arbiter #(.FIFO_AW(3), .STROBE_CYC(3), .GAP_CYC(0)) dut2 (
        .clk(clk), .rst(rst),
        .a_valid(a2Valid), .a_ready(a2Ready), .a_addr(a2Addr), .a_data(a2Data),
        .b_valid(b2Valid), .b_ready(b2Ready), .b_addr(b2Addr), .b_data(b2Data),
        .psg_addr(psgAddr2), .psg_data(psgData2), .psg_wr_n(psgWrN2),
        .busy(busy2), .fifo_level(fifoLevel2), .skip_pulse(skipPulse2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [7:0] aa, input logic [7:0] ad,
                                 input logic bv, input logic [7:0] ba, input logic [7:0] bd);
        aValid = av; aAddr = aa; aData = ad;
        bValid = bv; bAddr = ba; bData = bd;
    endtask

    // Scoreboard monitor: every falling psg_wr_n pops the next expected {addr,data}.
    logic       prevWrN = 1'b1;
    logic       haveLast = 1'b0;
    int         lastStart = 0;
    int         lowLen = 0;
    logic [7:0] heldAddr, heldData;
    always @(negedge clk) begin
        if (rst) begin
            prevWrN  = 1'b1;
            haveLast = 1'b0;
            lowLen   = 0;
        end else begin
            if (!psgWrN && prevWrN) begin
                strobeCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected strobe", {psgAddr, psgData}, 0);
                end else begin
                    logic [15:0] e;
                    e = expQ.pop_front();
                    checkOutput("strobe addr", psgAddr, e[15:8]);
                    checkOutput("strobe data", psgData, e[7:0]);
                end
                if (haveLast && checkSpacing) checkOutput("strobe spacing", cycleCount - lastStart, 10);
                lastStart = cycleCount;
                haveLast  = 1'b1;
                lowLen    = 1;
                heldAddr  = psgAddr;
                heldData  = psgData;
            end else if (!psgWrN) begin
                lowLen++;
                checkOutput("addr stable under strobe", {psgAddr, psgData}, {heldAddr, heldData});
            end else if (!prevWrN) begin
                checkOutput("strobe length", lowLen, 1);
            end
            if (skipPulse) skipCount++;
            prevWrN = psgWrN;
        end
    end

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        a2Valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expQ.delete();
    endtask

    task automatic pushA(input logic [7:0] ad, input logic [7:0] dt, input logic expectIssue);
        int n = 0;
        aValid = 1'b1; aAddr = ad; aData = dt;
        @(negedge clk);
        while (!aReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pushA accepted", aReady, 1);
        if (expectIssue) expQ.push_back({ad, dt});
        @(posedge clk);
        #1 aValid = 1'b0;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        @(negedge clk); #1;
        while ((busy || expQ.size() != 0) && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("drain busy", busy, 0);
        checkOutput("drain pending", expQ.size(), 0);
        @(posedge clk); #1;
    endtask

    vector_t vecs[8];
    logic [7:0] pat2;
    int ai, bi, n, pushes, strobeBase, skipBase, expLevel, savedStrobes;
    logic aFire, bFire, fire, sawFull;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        a2Valid = 1'b0; a2Addr = 8'h00; a2Data = 8'h00;
        b2Valid = 1'b0; b2Addr = 8'h00; b2Data = 8'h00;
        @(negedge clk);
        checkOutput("reset wr_n", psgWrN, 1);
        checkOutput("reset addr", psgAddr, 0);
        checkOutput("reset data", psgData, 0);
        checkOutput("reset level", fifoLevel, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset skip", skipPulse, 0);
        checkOutput("reset readies", {aReady, bReady}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single write: valid presented after edge N, strobe low after edge N+2 for one cycle.
        @(posedge clk); #1;
        aValid = 1'b1; aAddr = 8'h07; aData = 8'h38;
        expQ.push_back(16'h0738);
        @(negedge clk); checkOutput("t1 aReady", aReady, 1);
        @(posedge clk); #1 aValid = 1'b0;
        @(negedge clk);
        checkOutput("t1 wr_n before", psgWrN, 1);
        checkOutput("t1 level", fifoLevel, 1);
        checkOutput("t1 busy", busy, 1);
        @(negedge clk);
        checkOutput("t1 wr_n low", psgWrN, 0);
        checkOutput("t1 addr", psgAddr, 8'h07);
        checkOutput("t1 data", psgData, 8'h38);
        @(negedge clk);
        checkOutput("t1 wr_n high", psgWrN, 1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("t1 busy in gap", busy, 1);
        end
        @(negedge clk);
        checkOutput("t1 busy fall", busy, 0);
        @(posedge clk); #1;

        // Short-strobe build: strobes 3 cycles low separated by exactly 1 high cycle.
        a2Valid = 1'b1; a2Addr = 8'h01; a2Data = 8'hAA;
        @(negedge clk); checkOutput("p2 ready0", a2Ready, 1);
        @(posedge clk); #1 a2Addr = 8'h02; a2Data = 8'hBB;
        @(negedge clk); checkOutput("p2 ready1", a2Ready, 1);
        @(posedge clk); #1 a2Valid = 1'b0;
        pat2 = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("p2 wr_n cyc%0d", i), psgWrN2, pat2[i]);
            if (i == 0) checkOutput("p2 first write", {psgAddr2, psgData2}, 16'h01AA);
            if (i == 4) checkOutput("p2 second write", {psgAddr2, psgData2}, 16'h02BB);
        end
        @(negedge clk);
        checkOutput("p2 idle", {busy2, fifoLevel2, b2Ready, skipPulse2}, 0);

        // Arbitration vectors; after reset last grant is B so A wins the first tie.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].aV, 8'h10 + 8'(i), 8'hA0 + 8'(i), vecs[i].bV, 8'h30 + 8'(i), 8'hC0 + 8'(i));
            if (vecs[i].expA) expQ.push_back({8'h10 + 8'(i), 8'hA0 + 8'(i)});
            else if (vecs[i].expB) expQ.push_back({8'h30 + 8'(i), 8'hC0 + 8'(i)});
            @(negedge clk);
            checkOutput($sformatf("vec%0d aReady", i), aReady, vecs[i].expA);
            checkOutput($sformatf("vec%0d bReady", i), bReady, vecs[i].expB);
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        waitDrain(300);

        // Both requesters hold valid for four writes each: strict A/B alternation.
        doReset();
        for (int i = 0; i < 4; i++) begin
            expQ.push_back({8'h40 + 8'(i), 8'h11 + 8'(i)});
            expQ.push_back({8'h50 + 8'(i), 8'h22 + 8'(i)});
        end
        ai = 0; bi = 0; n = 0;
        applyStimulus(1'b1, 8'h40, 8'h11, 1'b1, 8'h50, 8'h22);
        while ((ai < 4 || bi < 4) && n < 200) begin
            @(negedge clk);
            aFire = aValid && aReady;
            bFire = bValid && bReady;
            checkOutput("rr single grant", aFire && bFire, 0);
            @(posedge clk); #1;
            if (aFire) ai++;
            if (bFire) bi++;
            aValid = (ai < 4); aAddr = 8'h40 + 8'(ai); aData = 8'h11 + 8'(ai);
            bValid = (bi < 4); bAddr = 8'h50 + 8'(bi); bData = 8'h22 + 8'(bi);
            n++;
        end
        checkOutput("rr all accepted", ai + bi, 8);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        waitDrain(300);

        // Requester B streams past the FIFO depth; ready must drop exactly while eight entries are held.
        doReset();
        strobeBase = strobeCount;
        for (int i = 0; i < 12; i++) expQ.push_back({8'h60 + 8'(i), 8'h80 + 8'(i)});
        bi = 0; pushes = 0; n = 0; sawFull = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h60, 8'h80);
        while (bi < 12 && n < 400) begin
            @(negedge clk); #1;
            expLevel = pushes - (strobeCount - strobeBase);
            checkOutput("full level", fifoLevel, expLevel);
            checkOutput("full bReady", bReady, (expLevel != 8) ? 1 : 0);
            if (expLevel == 8) sawFull = 1'b1;
            fire = bReady;
            @(posedge clk); #1;
            if (fire) begin
                pushes++;
                bi++;
                bAddr = 8'h60 + 8'(bi); bData = 8'h80 + 8'(bi);
                if (bi == 12) bValid = 1'b0;
            end
            n++;
        end
        checkOutput("full reached", sawFull, 1);
        checkOutput("full all accepted", bi, 12);
        waitDrain(600);

        // Reset asserted while wr_n is low releases the strobe at once and flushes the queue.
        doReset();
        pushA(8'h20, 8'h01, 1'b1);
        pushA(8'h21, 8'h02, 1'b1);
        pushA(8'h22, 8'h03, 1'b1);
        n = 0;
        @(negedge clk);
        while (psgWrN && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst found strobe", psgWrN, 0);
        rst = 1'b1;
        #1;
        checkOutput("rst wr_n", psgWrN, 1);
        checkOutput("rst level", fifoLevel, 0);
        checkOutput("rst busy", busy, 0);
        expQ.delete();
        savedStrobes = strobeCount;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("rst no strobes after", strobeCount - savedStrobes, 0);
        checkOutput("rst stays idle", {busy, fifoLevel}, 0);
        @(posedge clk); #1;

        // Repeated writes: a duplicate register write is dropped only when dedup is built in, never reg 13.
        doReset();
        checkSpacing = 1'b0;
        strobeBase = strobeCount;
        skipBase = skipCount;
        pushA(8'h00, 8'h55, 1'b1);
`ifdef PSG_WR_DEDUP_EN
        pushA(8'h00, 8'h55, 1'b0);
`else
        pushA(8'h00, 8'h55, 1'b1);
`endif
        pushA(8'h0D, 8'h09, 1'b1);
        pushA(8'h0D, 8'h09, 1'b1);
        waitDrain(200);
`ifdef PSG_WR_DEDUP_EN
        checkOutput("dedup strobes", strobeCount - strobeBase, 3);
        checkOutput("dedup skips", skipCount - skipBase, 1);
`else
        checkOutput("dedup strobes", strobeCount - strobeBase, 4);
        checkOutput("dedup skips", skipCount - skipBase, 0);
`endif
        checkSpacing = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

endmodule
